clcd_read_sequencer: RTL and testbench
======================================

Name: clcd_read_sequencer

Overview:
- Reads one byte from the HD44780 CLCD behind the PCF8574 I2C backpack (address 7'h27). The byte is either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- It is the read-direction counterpart of the CLCD nibble write generator, and sits between system_control and the shared i2c_master.
- Runs a six-step I2C sequence (E-high write, I2C read, E-low write, twice) and assembles the two 4-bit nibbles into an 8-bit result.

Parameters:
- I2C_ADDR, 7'h27, 7-bit PCF8574 slave address driven on o_addr.
- TIMEOUT, 1000, maximum clk cycles a step waits for an i_busy rise after o_valid asserts; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_p  input  1  synchronous, active-high reset.
- i_busy  input  1  i2c_master busy.
- i_rd_data  input  8  byte returned by i2c_master on a read; valid at the i_busy falling edge.
- o_valid  output  1  transaction request to i2c_master.
- o_RW  output  1  I2C direction: 0 = write, 1 = read.
- o_data  output  8  I2C write byte, bit order {D7..D4, BL, E, RW, RS}.
- o_addr  output  7  I2C slave address.
- i_valid  input  1  read request from system_control; sampled only in IDLE.
- i_RS  input  1  register select for the read; latched with i_valid.
- o_busy  output  1  high whenever state != IDLE.
- o_rd_data  output  8  assembled read byte.
- o_rd_valid  output  1  one-cycle pulse when o_rd_data updates.
- o_busy_flag  output  1  o_rd_data[7].
- o_ac  output  7  o_rd_data[6:0].
- o_error  output  1  one-cycle pulse on step timeout.

Behaviour:
- Reset values: o_valid=0, o_RW=0, o_data=0, o_addr=I2C_ADDR, o_rd_data=0, o_rd_valid=0, o_error=0, state=IDLE, so o_busy=0. Reset takes effect at any state; partial nibbles are discarded and no pulse is issued.
- States and step bytes (BL=1, RW=1 throughout):
  - IDLE.
  - W1: write {4'hF,1,1,1,RS}. D7..D4 are held high so the PCF8574 pins act as inputs.
  - R1: I2C read; capture the high nibble from i_rd_data[7:4].
  - W2: write {4'hF,1,0,1,RS}.
  - W3: write {4'hF,1,1,1,RS}.
  - R2: I2C read; capture the low nibble from i_rd_data[7:4].
  - W4: write {4'hF,1,0,1,RS}.
  - DONE.
  - Resulting write bytes: RS=0 gives E-high 8'hFE and E-low 8'hFA; RS=1 gives 8'hFF and 8'hFB.
- Transitions:
  - IDLE to W1 when i_valid=1; i_RS is latched at that edge.
  - Each step advances on the i_busy falling edge: W1, R1, W2, W3, R2, W4, then DONE.
  - DONE to IDLE after exactly one cycle.
  - i_valid in any state other than IDLE is ignored.
- Edge detection: i_busy is registered once. A rise is prev=0 and cur=1; a fall is prev=1 and cur=0. Both are evaluated on the registered value, so response latency is 1 cycle.
- Step handshake:
  - In the first cycle of a step, drive o_data (write steps only; o_data holds its value during read steps) and o_RW (0 for W steps, 1 for R steps), and set o_valid=1.
  - o_valid holds until a rise is detected, then clears on the next edge.
  - If i_busy is already high at step entry, o_valid stays high until a fresh rise is seen.
  - A fall before any rise in the current step is ignored.
  - After a step completes, the next step's o_valid asserts on the following cycle.
- Read capture: in R1 and R2, i_rd_data is sampled in the cycle the fall is detected.
- DONE:
  - o_rd_data <= {hi_nibble, lo_nibble} and o_rd_valid=1 for that single cycle.
  - o_busy stays 1 in DONE.
  - A new i_valid is accepted in the cycle after DONE (IDLE).
- Timeout:
  - A per-step counter starts when o_valid asserts.
  - If no rise is seen by count TIMEOUT: o_valid<=0, o_error pulses for 1 cycle, state goes to IDLE, o_rd_data is unchanged and there is no o_rd_valid.
  - The counter clears on each step entry.
- If a rise and the timeout occur in the same cycle, the rise wins.

Test Plan:
1. Reset: assert reset_p for 2 cycles mid-R1 -> next cycle all outputs at reset values, o_addr=7'h27, o_busy=0, no o_rd_valid.
2. RS=0 read; master model returns 8'h8F (R1) and 8'h3F (R2) -> I2C sequence W 8'hFE, R, W 8'hFA, W 8'hFE, R, W 8'hFA with o_RW=0,1,0,0,1,0. Then o_rd_data=8'h83, o_busy_flag=1, o_ac=7'h03, o_rd_valid pulses for 1 cycle, o_busy falls 1 cycle later.
3. RS=1 read; master returns 8'h4F and 8'h1F -> writes 8'hFF/8'hFB, o_rd_data=8'h41, o_busy_flag=0.
4. i_valid pulsed during W3 -> ignored. Exactly one o_rd_valid, then a new request in IDLE runs a full second sequence.
5. TIMEOUT=16, master never raises i_busy in W1 -> o_valid high for 16 cycles, then o_error 1-cycle pulse, state IDLE, o_rd_valid never asserts, o_rd_data unchanged.
6. i_busy held high at W2 entry -> o_valid stays high until i_busy falls and rises again, then clears the cycle after the detected rise.

Source files
------------

// File: rtl/clcd_read_sequencer.sv
// HD44780 read sequencer over a PCF8574 I2C backpack: E-high write, I2C read,
// E-low write, done twice, assembling the two returned nibbles into one byte.
module clcd_read_sequencer #(
    parameter logic [6:0]  I2C_ADDR = 7'h27,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       i_busy,
    input  logic [7:0] i_rd_data,
    output logic       o_valid,
    output logic       o_RW,
    output logic [7:0] o_data,
    output logic [6:0] o_addr,
    input  logic       i_valid,
    input  logic       i_RS,
    output logic       o_busy,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy_flag,
    output logic [6:0] o_ac,
    output logic       o_error
);

    typedef enum logic [2:0] {IDLE, W1, R1, W2, W3, R2, W4, DONE} state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state, state_n;
    logic          valid_n, rw_n, rd_valid_n, error_n;
    logic [7:0]    data_n, rd_data_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          seen, seen_n;
    logic [3:0]    hi, hi_n, lo, lo_n;
    logic          rs, rs_n;
    logic          busy_cur, busy_prev;
    logic          rise, fall, is_read, e_high;

    assign rise    = busy_cur & ~busy_prev;
    assign fall    = ~busy_cur & busy_prev;
    assign is_read = (state == R1) || (state == R2);
    assign e_high  = (state == W1) || (state == W3);

    assign o_addr      = I2C_ADDR;
    assign o_busy      = (state != IDLE);
    assign o_busy_flag = o_rd_data[7];
    assign o_ac        = o_rd_data[6:0];

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_RW       <= 1'b0;
            o_data     <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_error    <= 1'b0;
            cnt        <= '0;
            seen       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            rs         <= 1'b0;
            busy_cur   <= 1'b0;
            busy_prev  <= 1'b0;
        end else begin
            state      <= state_n;
            o_valid    <= valid_n;
            o_RW       <= rw_n;
            o_data     <= data_n;
            o_rd_data  <= rd_data_n;
            o_rd_valid <= rd_valid_n;
            o_error    <= error_n;
            cnt        <= cnt_n;
            seen       <= seen_n;
            hi         <= hi_n;
            lo         <= lo_n;
            rs         <= rs_n;
            busy_cur   <= i_busy;
            busy_prev  <= busy_cur;
        end
    end

    always_comb begin
        state_n    = state;
        valid_n    = o_valid;
        rw_n       = o_RW;
        data_n     = o_data;
        rd_data_n  = o_rd_data;
        rd_valid_n = 1'b0;
        error_n    = 1'b0;
        cnt_n      = cnt;
        seen_n     = seen;
        hi_n       = hi;
        lo_n       = lo;
        rs_n       = rs;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_n = W1;
                    rs_n    = i_RS;
                end
            end
            DONE: state_n = IDLE;
            default: begin
                // A step is in its first cycle when no request is out and no rise seen yet
                if (!o_valid && !seen) begin
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    rw_n    = is_read;
                    if (!is_read)
                        data_n = {4'hF, 1'b1, e_high, 1'b1, rs};
                end else if (o_valid) begin
                    if (rise) begin
                        valid_n = 1'b0;
                        seen_n  = 1'b1;
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        valid_n = 1'b0;
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else if (fall) begin
                    seen_n = 1'b0;
                    case (state)
                        W1: state_n = R1;
                        R1: begin
                            state_n = W2;
                            hi_n    = i_rd_data[7:4];
                        end
                        W2: state_n = W3;
                        W3: state_n = R2;
                        R2: begin
                            state_n = W4;
                            lo_n    = i_rd_data[7:4];
                        end
                        default: begin
                            state_n    = DONE;
                            rd_data_n  = {hi, lo};
                            rd_valid_n = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_clcd_read_sequencer.sv
// Randomized bench for clcd_read_sequencer: the bench plays the i2c_master and
// checks the I2C step list and assembled byte against a nibble-level model.
module tb_clcd_read_sequencer;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       i_busy;
    logic [7:0] i_rd_data;
    logic       o_valid;
    logic       o_RW;
    logic [7:0] o_data;
    logic [6:0] o_addr;
    logic       i_valid;
    logic       i_RS;
    logic       o_busy;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_busy_flag;
    logic [6:0] o_ac;
    logic       o_error;

    int checks   = 0;
    int failures = 0;
    int rv_count = 0;
    int er_count = 0;

    clcd_read_sequencer #(.I2C_ADDR(7'h27), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .i_busy     (i_busy),
        .i_rd_data  (i_rd_data),
        .o_valid    (o_valid),
        .o_RW       (o_RW),
        .o_data     (o_data),
        .o_addr     (o_addr),
        .i_valid    (i_valid),
        .i_RS       (i_RS),
        .o_busy     (o_busy),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_busy_flag(o_busy_flag),
        .o_ac       (o_ac),
        .o_error    (o_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_rd_valid) rv_count++;
        if (o_error) er_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One I2C transaction served by the bench acting as i2c_master.
    task automatic serve_step(input bit exp_rw, input logic [7:0] exp_data, input logic [7:0] rd,
                              input bit pre_high, input bit leave_high, input bit poke);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_up", o_valid, 1);
        if (!o_valid) return;
        check("rw", o_RW, exp_rw);
        if (!exp_rw) check("wdata", o_data, exp_data);
        check("busy_step", o_busy, 1);
        if (poke) begin
            i_valid = 1'b1;
            i_RS    = 1'($urandom);
            @(negedge clk);
            i_valid = 1'b0;
        end
        if (pre_high) begin
            repeat (4) begin
                @(negedge clk);
                check("hold_hi", o_valid, 1);
            end
            i_busy = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("hold_fall", o_valid, 1);
            end
        end else begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("valid_hold", o_valid, 1);
            end
        end
        i_busy    = 1'b1;
        i_rd_data = 8'($urandom);
        n = 0;
        while (o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("valid_clear", o_valid, 0);
        if (pre_high) check("clear_lat", 32'(n <= 3), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i_rd_data = rd;
        i_busy    = 1'b0;
        @(negedge clk);
        if (leave_high) i_busy = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_before", o_busy, 0);
    endtask

    task automatic read_txn(input bit rs, input logic [7:0] b1, input logic [7:0] b2,
                            input bit poke_w3, input bit hold_w2);
        logic [7:0] eh, el, exp;
        int n, rv0;
        eh  = 8'hFE | {7'b0, rs};
        el  = 8'hFA | {7'b0, rs};
        exp = {b1[7:4], b2[7:4]};
        wait_idle();
        rv0 = rv_count;
        i_valid = 1'b1;
        i_RS    = rs;
        @(negedge clk);
        i_valid = 1'b0;
        i_RS    = ~rs;
        serve_step(1'b0, eh, 8'h00, 1'b0, 1'b0, 1'b0);
        serve_step(1'b1, 8'h00, b1, 1'b0, hold_w2, 1'b0);
        serve_step(1'b0, el, 8'h00, hold_w2, 1'b0, 1'b0);
        serve_step(1'b0, eh, 8'h00, 1'b0, 1'b0, poke_w3);
        serve_step(1'b1, 8'h00, b2, 1'b0, 1'b0, 1'b0);
        serve_step(1'b0, el, 8'h00, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!o_rd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rd_valid", o_rd_valid, 1);
        check("rd_data", o_rd_data, exp);
        check("busy_flag", o_busy_flag, exp[7]);
        check("ac", o_ac, exp[6:0]);
        check("busy_done", o_busy, 1);
        @(negedge clk);
        check("rd_pulse", o_rd_valid, 0);
        check("busy_fall", o_busy, 0);
        repeat (4) begin
            @(negedge clk);
            check("stay_idle", o_busy, 0);
        end
        check("one_pulse", rv_count - rv0, 1);
    endtask

    task automatic check_reset_values();
        check("rst_valid", o_valid, 0);
        check("rst_rw", o_RW, 0);
        check("rst_data", o_data, 0);
        check("rst_addr", o_addr, 7'h27);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_error", o_error, 0);
        check("rst_busy", o_busy, 0);
    endtask

    initial begin
        int n, rv0, er0;
        logic [7:0] saved;
        reset_p   = 1'b1;
        i_busy    = 1'b0;
        i_rd_data = 8'h00;
        i_valid   = 1'b0;
        i_RS      = 1'b0;
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        @(negedge clk);
        check_reset_values();

        read_txn(1'b0, 8'h8F, 8'h3F, 1'b0, 1'b0);
        read_txn(1'b1, 8'h4F, 8'h1F, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            read_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

        // i_valid during W3 is ignored, then a fresh request runs normally
        read_txn(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        read_txn(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);

        // i_busy already high when W2 begins
        read_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);

        // Timeout in W1: master never responds
        wait_idle();
        saved = o_rd_data;
        rv0 = rv_count;
        er0 = er_count;
        i_valid = 1'b1;
        i_RS    = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_valid_up", o_valid, 1);
        n = 0;
        while (o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_len", n, 16);
        check("to_error", o_error, 1);
        check("to_idle", o_busy, 0);
        @(negedge clk);
        check("to_err_pulse", o_error, 0);
        repeat (5) @(negedge clk);
        check("to_err_count", er_count - er0, 1);
        check("to_no_rv", rv_count - rv0, 0);
        check("to_rd_data", o_rd_data, saved);
        check("to_valid_low", o_valid, 0);

        // Reset in the middle of R1
        rv0 = rv_count;
        i_valid = 1'b1;
        i_RS    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        serve_step(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r1_valid", o_valid, 1);
        check("r1_rw", o_RW, 1);
        i_busy = 1'b1;
        @(negedge clk);
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        i_busy  = 1'b0;
        @(negedge clk);
        check_reset_values();
        repeat (5) @(negedge clk);
        check("rst_no_rv", rv_count - rv0, 0);
        check("rst_stay_idle", o_busy, 0);

        read_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
